sync_fifo_prog: RTL and testbench

Single-clock, parametrised synchronous FIFO. It is the single-domain successor to the team's dual-clock FIFO and serves blocks that share one clock.
Adds features the dual-clock FIFO lacks:
- occupancy count
- runtime-programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- selectable standard or first-word-fall-through (FWFT) read mode
It sits between a producer and a consumer in the same clock domain, for example a UART or processing datapath buffer.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/sync_fifo_prog_if.sv | 38 +++
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo_prog.sv | 110 +++++++++++
 tb/tb_sync_fifo_prog.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock programmable FIFO.
package fifo_pkg;

    // Read-mode selection for the FWFT parameter
    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    // Depth must be a power of two and at least 4 so pointer wrap works
    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    // Pointers and count carry one extra bit to tell full from empty
    function automatic int unsigned ptr_width(input int unsigned add_width);
        return add_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bus of the programmable FIFO.
interface sync_fifo_prog_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADD_WIDTH  = 4
);
    localparam int unsigned PTR_WIDTH = ptr_width(ADD_WIDTH);

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_inc;
    logic                  rd_inc;
    logic [PTR_WIDTH-1:0]  af_level;
    logic [PTR_WIDTH-1:0]  ae_level;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [PTR_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_data, wr_inc, rd_inc, af_level, ae_level, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_data, wr_inc, rd_inc, af_level, ae_level, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned ADD_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADD_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADD_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Store the incoming word; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy, programmable thresholds, sticky errors
// and selectable standard / first-word-fall-through read.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned ADD_WIDTH  = $clog2(MEM_DEPTH),
    parameter int unsigned FWFT       = FIFO_STD
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_prog_if.slave  bus
);

    localparam int unsigned PTR_WIDTH = ptr_width(ADD_WIDTH);

    if (!depth_ok(MEM_DEPTH)) begin : g_bad_depth
        $error("sync_fifo_prog: MEM_DEPTH must be a power of two and at least 4");
    end

    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  underflow;
    logic                  full_c;
    logic                  empty_c;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign full_c  = (count == PTR_WIDTH'(MEM_DEPTH));
    assign empty_c = (count == '0);
    // Full blocks the write and empty blocks the read: no pass-through/bypass
    assign wr_acc  = bus.wr_inc & ~full_c;
    assign rd_acc  = bus.rd_inc & ~empty_c;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .ADD_WIDTH  (ADD_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADD_WIDTH-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr[ADD_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // Pointers, occupancy and sticky error flags (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + PTR_WIDTH'(1);
                2'b01:   count <= count - PTR_WIDTH'(1);
                default: count <= count;
            endcase
            overflow  <= (overflow  & ~bus.clr_err) | (bus.wr_inc & full_c);
            underflow <= (underflow & ~bus.clr_err) | (bus.rd_inc & empty_c);
        end
    end

    assign bus.count        = count;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count >= bus.af_level);
    assign bus.almost_empty = (count <= bus.ae_level);
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word is presented directly; drive zero while nothing is stored
        assign bus.rd_data  = empty_c ? '0 : mem_rdata;
        assign bus.rd_valid = ~empty_c;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  rd_valid_q;

        // Registered read: data lands the cycle after the pop and then holds
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q       <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_q <= mem_rdata;
                end
            end
        end

        assign bus.rd_data  = rd_q;
        assign bus.rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog in standard and FWFT read modes.
module tb_sync_fifo_prog;
    import fifo_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic clk = 1'b0;
    logic rst_s = 1'b1;
    logic rst_f = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus_s ();
    sync_fifo_prog_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus_f ();

    sync_fifo_prog #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADD_WIDTH(AW), .FWFT(FIFO_STD))
        u_std (.clk(clk), .rst(rst_s), .bus(bus_s));

    sync_fifo_prog #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADD_WIDTH(AW), .FWFT(FIFO_FWFT))
        u_fwft (.clk(clk), .rst(rst_f), .bus(bus_f));

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  sb_s[$];
    logic [7:0]  sb_f[$];
    logic        ov_m = 1'b0;
    logic        un_m = 1'b0;
    logic [7:0]  last_m = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Standard-mode cycle: model acceptance, clock once, compare everything
    task automatic step_s(input logic w, input logic [7:0] d, input logic r, input logic clr);
        int   pre;
        logic wacc;
        logic racc;
        pre  = sb_s.size();
        wacc = w && (pre < int'(DEPTH));
        racc = r && (pre > 0);
        bus_s.wr_inc  = w;
        bus_s.wr_data = d;
        bus_s.rd_inc  = r;
        bus_s.clr_err = clr;
        if (wacc) sb_s.push_back(d);
        ov_m = (ov_m & ~clr) | (w && (pre == int'(DEPTH)));
        un_m = (un_m & ~clr) | (r && (pre == 0));
        @(posedge clk);
        @(negedge clk);
        bus_s.wr_inc  = 1'b0;
        bus_s.rd_inc  = 1'b0;
        bus_s.clr_err = 1'b0;
        if (racc) last_m = sb_s.pop_front();
        check_val("s_rd_valid", 32'(bus_s.rd_valid), 32'(racc));
        check_val("s_rd_data", 32'(bus_s.rd_data), 32'(last_m));
        check_val("s_count", 32'(bus_s.count), 32'(sb_s.size()));
        check_val("s_empty", 32'(bus_s.empty), 32'(sb_s.size() == 0));
        check_val("s_full", 32'(bus_s.full), 32'(sb_s.size() == int'(DEPTH)));
        check_val("s_almost_full", 32'(bus_s.almost_full),
                  32'(sb_s.size() >= int'(bus_s.af_level)));
        check_val("s_almost_empty", 32'(bus_s.almost_empty),
                  32'(sb_s.size() <= int'(bus_s.ae_level)));
        check_val("s_overflow", 32'(bus_s.overflow), 32'(ov_m));
        check_val("s_underflow", 32'(bus_s.underflow), 32'(un_m));
    endtask

    task automatic reset_s();
        bus_s.wr_inc  = 1'b0;
        bus_s.rd_inc  = 1'b0;
        bus_s.clr_err = 1'b0;
        rst_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb_s.delete();
        ov_m   = 1'b0;
        un_m   = 1'b0;
        last_m = 8'h00;
        check_val("rst_count", 32'(bus_s.count), 32'd0);
        check_val("rst_empty", 32'(bus_s.empty), 32'd1);
        check_val("rst_full", 32'(bus_s.full), 32'd0);
        check_val("rst_overflow", 32'(bus_s.overflow), 32'd0);
        check_val("rst_underflow", 32'(bus_s.underflow), 32'd0);
        check_val("rst_rd_valid", 32'(bus_s.rd_valid), 32'd0);
        check_val("rst_rd_data", 32'(bus_s.rd_data), 32'd0);
        check_val("rst_almost_empty", 32'(bus_s.almost_empty), 32'd1);
        check_val("rst_almost_full", 32'(bus_s.almost_full), 32'(bus_s.af_level == 5'd0));
        rst_s = 1'b0;
    endtask

    // FWFT-mode cycle: head of scoreboard must be on rd_data whenever non-empty
    task automatic step_f(input logic w, input logic [7:0] d, input logic r);
        int   pre;
        logic wacc;
        logic racc;
        pre  = sb_f.size();
        wacc = w && (pre < int'(DEPTH));
        racc = r && (pre > 0);
        bus_f.wr_inc  = w;
        bus_f.wr_data = d;
        bus_f.rd_inc  = r;
        if (wacc) sb_f.push_back(d);
        if (racc) void'(sb_f.pop_front());
        @(posedge clk);
        @(negedge clk);
        bus_f.wr_inc = 1'b0;
        bus_f.rd_inc = 1'b0;
        check_val("f_count", 32'(bus_f.count), 32'(sb_f.size()));
        check_val("f_rd_valid", 32'(bus_f.rd_valid), 32'(sb_f.size() > 0));
        if (sb_f.size() > 0) check_val("f_rd_data", 32'(bus_f.rd_data), 32'(sb_f[0]));
    endtask

    task automatic reset_f();
        bus_f.wr_inc = 1'b0;
        bus_f.rd_inc = 1'b0;
        rst_f = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_f = 1'b0;
        sb_f.delete();
        check_val("f_rst_count", 32'(bus_f.count), 32'd0);
        check_val("f_rst_empty", 32'(bus_f.empty), 32'd1);
        check_val("f_rst_rd_valid", 32'(bus_f.rd_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_s.wr_data = '0; bus_s.wr_inc = 1'b0; bus_s.rd_inc = 1'b0; bus_s.clr_err = 1'b0;
        bus_s.af_level = 5'd0; bus_s.ae_level = 5'd0;
        bus_f.wr_data = '0; bus_f.wr_inc = 1'b0; bus_f.rd_inc = 1'b0; bus_f.clr_err = 1'b0;
        bus_f.af_level = 5'd12; bus_f.ae_level = 5'd2;
        @(negedge clk);

        // Reset with af_level 0 so almost_full must read 1
        reset_s();
        bus_s.af_level = 5'd12;
        bus_s.ae_level = 5'd2;

        // Single word through standard read path
        step_s(1'b1, 8'hAA, 1'b0, 1'b0);
        step_s(1'b0, 8'h00, 1'b1, 1'b0);
        step_s(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill, overflow attempt, drain in order
        for (int i = 0; i < 16; i++) step_s(1'b1, 8'(i), 1'b0, 1'b0);
        step_s(1'b1, 8'hBB, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0);
        step_s(1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous access at count 5 and at full
        for (int i = 0; i < 5; i++) step_s(1'b1, 8'(8'h40 + 8'(i)), 1'b0, 1'b0);
        step_s(1'b1, 8'h50, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) step_s(1'b1, 8'(8'h60 + 8'(i)), 1'b0, 1'b0);
        step_s(1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0);
        step_s(1'b0, 8'h00, 1'b0, 1'b1);

        // Threshold sweep up through af_level and back down through ae_level
        for (int i = 0; i < 13; i++) step_s(1'b1, 8'($urandom_range(255)), 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0);

        // Underflow, clear alone, clear racing a new underflow
        step_s(1'b0, 8'h00, 1'b1, 1'b0);
        step_s(1'b0, 8'h00, 1'b0, 1'b1);
        step_s(1'b0, 8'h00, 1'b1, 1'b1);
        step_s(1'b0, 8'h00, 1'b0, 1'b1);

        // Mid-operation reset discards contents
        for (int i = 0; i < 3; i++) step_s(1'b1, 8'(8'hC0 + 8'(i)), 1'b0, 1'b0);
        reset_s();
        step_s(1'b0, 8'h00, 1'b1, 1'b0);

        // FWFT: fall-through, pointer wrap, reset at count 7
        reset_f();
        step_f(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 40; i++) step_f(1'b1, 8'($urandom_range(255)), 1'b1);
        for (int i = 0; i < 6; i++) step_f(1'b1, 8'($urandom_range(255)), 1'b0);
        check_val("f_count_pre_rst", 32'(bus_f.count), 32'd7);
        reset_f();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
